// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller-to-datapath signal bundle for the multicycle RV32I core
interface multicycle_ctrl_if #(
  parameter int ALUCTRL_WIDTH = 4,
  parameter int DATA_WIDTH    = 32
);
  logic [DATA_WIDTH-1:0]    Instr;
  logic                     ZERO;
  logic                     MemReady;
  logic [ALUCTRL_WIDTH-1:0] ALUCtrl;
  logic [1:0]               ALUSrcA;
  logic [1:0]               ALUSrcB;
  logic [1:0]               ResultSrc;
  logic [2:0]               ImmSrc;
  logic                     AdrSrc;
  logic                     PCWrite;
  logic                     IRWrite;
  logic                     RegWrite;
  logic                     MemWrite;
  logic                     MemRead;
  logic                     InstrDone;
  logic                     Illegal;

  // Controller side: consumes instruction, ALU flag and memory handshake.
  modport master (
    input  Instr, ZERO, MemReady,
    output ALUCtrl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
           PCWrite, IRWrite, RegWrite, MemWrite, MemRead, InstrDone, Illegal
  );

  // Datapath side: supplies instruction, ALU flag and memory handshake.
  modport slave (
    output Instr, ZERO, MemReady,
    input  ALUCtrl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
           PCWrite, IRWrite, RegWrite, MemWrite, MemRead, InstrDone, Illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM sequencing the multicycle RV32I datapath
module multicycle_ctrl #(
  parameter int ALUCTRL_WIDTH = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH-1:0] instr;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  instr_unused;

  assign instr        = bus.Instr;
  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  // Register and destination fields are routed by the datapath, not decoded here.
  assign instr_unused = ^{instr[24:15], instr[11:7]};

  logic       r_legal;
  logic       i_legal;
  logic       b_legal;
  logic       mem_legal;
  logic       is_store;
  logic       br_taken;
  logic [3:0] alu_r;
  logic [3:0] alu_i;
  logic [3:0] alu_br;
  logic [2:0] imm_dec;

  // Only SUB and SRA use the alternate funct7; SLLI needs a clean upper field.
  assign r_legal   = (funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  assign i_legal   = (funct3 != 3'b001) || (funct7 == 7'b0000000);
  assign b_legal   = (funct3[2:1] != 2'b01);
  assign mem_legal = (funct3 == 3'b010);
  assign is_store  = (opcode == OP_STORE);

  // Instr[30] selects SUB/SRA for R-type; for immediates it only means SRAI.
  assign alu_r  = {instr[30], funct3};
  assign alu_i  = {(funct3 == 3'b101) & instr[30], funct3};
  assign alu_br = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;

  // BNE, BLT and BLTU take when the compare result is non-zero; the rest on zero.
  assign br_taken = bus.ZERO ^ (funct3[0] ^ funct3[2]);

  // Immediate format needed by the target/offset add in DECODE.
  always_comb begin
    imm_dec = IMM_I;
    case (opcode)
      OP_STORE:  imm_dec = IMM_S;
      OP_BRANCH: imm_dec = IMM_B;
      OP_JAL:    imm_dec = IMM_J;
      OP_LUI:    imm_dec = IMM_U;
      default:   imm_dec = IMM_I;
    endcase
  end

  logic [3:0] alu_ctrl;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] res_src;
  logic [2:0] imm_src;
  logic       adr_src;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       mem_read;
  logic       instr_done;
  logic       illegal;

  // State register; reset always restarts at instruction fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Per-state datapath controls and next-state selection, squashed while in reset.
  always_comb begin
    state_nxt  = state;
    alu_ctrl   = ALU_ADD;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    res_src    = RES_ALUOUT;
    imm_src    = IMM_I;
    adr_src    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        src_a    = SRCA_PC;
        src_b    = SRCB_FOUR;
        res_src  = RES_ALU;
        ir_write = bus.MemReady;
        pc_write = bus.MemReady;
        if (bus.MemReady) begin
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
        imm_src = imm_dec;
        case (opcode)
          OP_R:              state_nxt = r_legal ? S_EXEC_R : S_TRAP;
          OP_I:              state_nxt = i_legal ? S_EXEC_I : S_TRAP;
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
          OP_BRANCH:         state_nxt = b_legal ? S_BRANCH : S_TRAP;
          OP_JAL:            state_nxt = S_JAL;
          OP_LUI:            state_nxt = S_LUI;
          default:           state_nxt = S_TRAP;
        endcase
      end

      S_EXEC_R: begin
        src_a     = SRCA_RS1;
        src_b     = SRCB_RS2;
        alu_ctrl  = alu_r;
        state_nxt = S_ALU_WB;
      end

      S_EXEC_I: begin
        src_a     = SRCA_RS1;
        src_b     = SRCB_IMM;
        imm_src   = IMM_I;
        alu_ctrl  = alu_i;
        state_nxt = S_ALU_WB;
      end

      S_ALU_WB: begin
        res_src    = RES_ALUOUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_MEM_ADDR: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        imm_src = is_store ? IMM_S : IMM_I;
        if (!mem_legal) begin
          state_nxt = S_TRAP;
        end else if (is_store) begin
          state_nxt = S_MEM_WR;
        end else begin
          state_nxt = S_MEM_RD;
        end
      end

      S_MEM_RD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (bus.MemReady) begin
          state_nxt = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        res_src    = RES_RDATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_MEM_WR: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = bus.MemReady;
        if (bus.MemReady) begin
          state_nxt = S_FETCH;
        end
      end

      S_BRANCH: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_RS2;
        res_src    = RES_ALUOUT;
        alu_ctrl   = alu_br;
        pc_write   = br_taken;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_JAL: begin
        // Jump target from DECODE sits in ALUOut; the link value OldPC+4 is computed alongside.
        pc_write  = 1'b1;
        res_src   = RES_ALUOUT;
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_FOUR;
        state_nxt = S_ALU_WB;
      end

      S_LUI: begin
        src_a     = SRCA_ZERO;
        src_b     = SRCB_IMM;
        imm_src   = IMM_U;
        state_nxt = S_ALU_WB;
      end

      S_TRAP: begin
        illegal = 1'b1;
      end

      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    if (rst) begin
      alu_ctrl   = ALU_ADD;
      src_a      = SRCA_PC;
      src_b      = SRCB_RS2;
      res_src    = RES_ALUOUT;
      imm_src    = IMM_I;
      adr_src    = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.ALUCtrl   = ALUCTRL_WIDTH'(alu_ctrl);
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.ResultSrc = res_src;
  assign bus.ImmSrc    = imm_src;
  assign bus.AdrSrc    = adr_src;
  assign bus.PCWrite   = pc_write;
  assign bus.IRWrite   = ir_write;
  assign bus.RegWrite  = reg_write;
  assign bus.MemWrite  = mem_write;
  assign bus.MemRead   = mem_read;
  assign bus.InstrDone = instr_done;
  assign bus.Illegal   = illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.ALUCTRL_WIDTH(4), .DATA_WIDTH(32)) bus ();

  multicycle_ctrl #(.ALUCTRL_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // One cycle of stimulus plus the outputs the controller must show in it.
  typedef struct packed {
    logic [31:0] ins;
    logic        rs;
    logic        mrdy;
    logic        z;
    logic [3:0]  alu;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [1:0]  res;
    logic [2:0]  imm;
    logic        adr;
    logic        pcw;
    logic        irw;
    logic        rw;
    logic        mw;
    logic        mr;
    logic        done;
    logic        ill;
  } rec_t;

  rec_t q[$];
  rec_t exp_r;
  logic exp_valid = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   done_want = 0;

  function automatic logic [21:0] outs(rec_t r);
    return {r.alu, r.a, r.b, r.res, r.imm, r.adr, r.pcw, r.irw, r.rw, r.mw, r.mr, r.done, r.ill};
  endfunction

  function automatic rec_t base(logic [31:0] ins);
    rec_t r = '0;
    r.ins  = ins;
    r.mrdy = 1'($urandom);
    r.z    = 1'($urandom);
    return r;
  endfunction

  function automatic logic [3:0] op_alu(logic [2:0] f3, logic alt);
    case (f3)
      3'd0:    return alt ? 4'b1000 : 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0011;
      3'd4:    return 4'b0100;
      3'd5:    return alt ? 4'b1101 : 4'b0101;
      3'd6:    return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] opc);
    if (opc == OP_S)   return 3'b001;
    if (opc == OP_B)   return 3'b010;
    if (opc == OP_JAL) return 3'b011;
    if (opc == OP_LUI) return 3'b100;
    return 3'b000;
  endfunction

  function automatic void reset_recs(logic [31:0] ins, int n, logic mrdy);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r      = base(ins);
      r.rs   = 1'b1;
      r.mrdy = mrdy;
      q.push_back(r);
    end
  endfunction

  function automatic void writeback(logic [31:0] ins);
    rec_t r = base(ins);
    r.rw   = 1'b1;
    r.done = 1'b1;
    q.push_back(r);
  endfunction

  // Expands one instruction into its expected cycles: wf fetch waits, wm data waits, z branch flag.
  function automatic void build(logic [31:0] ins, int wf, int wm, logic z);
    rec_t       r;
    logic [6:0] opc  = ins[6:0];
    logic [2:0] f3   = ins[14:12];
    logic [6:0] f7   = ins[31:25];
    bit         trap = 1'b0;
    bit         tk;
    for (int i = 0; i <= wf; i++) begin
      r      = base(ins);
      r.mr   = 1'b1;
      r.b    = 2'b10;
      r.res  = 2'b10;
      r.mrdy = (i == wf);
      r.irw  = r.mrdy;
      r.pcw  = r.mrdy;
      q.push_back(r);
    end
    r     = base(ins);
    r.a   = 2'b01;
    r.b   = 2'b01;
    r.imm = imm_of(opc);
    q.push_back(r);
    case (opc)
      OP_R: begin
        if (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) begin
          r     = base(ins);
          r.a   = 2'b10;
          r.alu = op_alu(f3, f7 == 7'b0100000);
          q.push_back(r);
          writeback(ins);
        end else begin
          trap = 1'b1;
        end
      end
      OP_I: begin
        if (f3 == 3'd1 && f7 != 7'd0) begin
          trap = 1'b1;
        end else begin
          r     = base(ins);
          r.a   = 2'b10;
          r.b   = 2'b01;
          r.alu = op_alu(f3, f3 == 3'd5 && ins[30]);
          q.push_back(r);
          writeback(ins);
        end
      end
      OP_L, OP_S: begin
        r     = base(ins);
        r.a   = 2'b10;
        r.b   = 2'b01;
        r.imm = (opc == OP_S) ? 3'b001 : 3'b000;
        q.push_back(r);
        if (f3 != 3'd2) begin
          trap = 1'b1;
        end else begin
          for (int i = 0; i <= wm; i++) begin
            r      = base(ins);
            r.adr  = 1'b1;
            r.mrdy = (i == wm);
            if (opc == OP_L) r.mr = 1'b1;
            else begin
              r.mw   = 1'b1;
              r.done = r.mrdy;
            end
            q.push_back(r);
          end
          if (opc == OP_L) begin
            r      = base(ins);
            r.res  = 2'b01;
            r.rw   = 1'b1;
            r.done = 1'b1;
            q.push_back(r);
          end
        end
      end
      OP_B: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          trap = 1'b1;
        end else begin
          r   = base(ins);
          r.a = 2'b10;
          r.z = z;
          case (f3)
            3'd0:    begin r.alu = 4'b1000; tk = z;  end
            3'd1:    begin r.alu = 4'b1000; tk = !z; end
            3'd4:    begin r.alu = 4'b0010; tk = !z; end
            3'd5:    begin r.alu = 4'b0010; tk = z;  end
            3'd6:    begin r.alu = 4'b0011; tk = !z; end
            default: begin r.alu = 4'b0011; tk = z;  end
          endcase
          r.pcw  = tk;
          r.done = 1'b1;
          q.push_back(r);
        end
      end
      OP_JAL: begin
        r     = base(ins);
        r.pcw = 1'b1;
        r.a   = 2'b01;
        r.b   = 2'b10;
        q.push_back(r);
        writeback(ins);
      end
      OP_LUI: begin
        r     = base(ins);
        r.a   = 2'b11;
        r.b   = 2'b01;
        r.imm = 3'b100;
        q.push_back(r);
        writeback(ins);
      end
      default: trap = 1'b1;
    endcase
    if (trap) begin
      for (int i = 0; i < 3; i++) begin
        r     = base(ins);
        r.ill = 1'b1;
        q.push_back(r);
      end
      reset_recs(ins, 2, 1'($urandom));
    end
  endfunction

  function automatic bit legal_op(logic [6:0] o);
    return o == OP_R || o == OP_I || o == OP_L || o == OP_S || o == OP_B || o == OP_JAL || o == OP_LUI;
  endfunction

  function automatic logic [31:0] gen(int kind);
    logic [31:0] w  = $urandom;
    logic [2:0]  f3 = 3'($urandom);
    logic [6:0]  f7;
    logic [6:0]  o;
    case (kind)
      0: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0;
        w  = {f7, w[24:15], f3, w[11:7], OP_R};
      end
      1: begin
        f7 = 7'($urandom);
        if (f7 == 7'd0) f7 = 7'b0000001;
        if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) f3 = 3'd2;
        w = {f7, w[24:15], f3, w[11:7], OP_R};
      end
      2: begin
        if (f3 == 3'd1) w[31:25] = 7'd0;
        w = {w[31:15], f3, w[11:7], OP_I};
      end
      3: begin
        f7 = 7'($urandom);
        if (f7 == 7'd0) f7 = 7'b0100000;
        w = {f7, w[24:15], 3'd1, w[11:7], OP_I};
      end
      4: w = {w[31:15], 3'd2, w[11:7], OP_L};
      5: w = {w[31:15], 3'd2, w[11:7], OP_S};
      6: begin
        if (f3 == 3'd2) f3 = 3'd3;
        w = {w[31:15], f3, w[11:7], w[0] ? OP_S : OP_L};
      end
      7: begin
        if (f3[2:1] == 2'b01) f3[2] = 1'b1;
        w = {w[31:15], f3, w[11:7], OP_B};
      end
      8: w = {w[31:15], 2'b01, w[12], w[11:7], OP_B};
      9: w = {w[31:7], OP_JAL};
      10: w = {w[31:7], OP_LUI};
      default: begin
        o = 7'($urandom);
        for (int t = 0; t < 64 && legal_op(o); t++) o = 7'($urandom);
        if (legal_op(o)) o = 7'b1111111;
        w = {w[31:7], o};
      end
    endcase
    return w;
  endfunction

  task automatic pin(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic run_q();
    rec_t r;
    while (q.size() > 0) begin
      r            = q.pop_front();
      rst          = r.rs;
      bus.Instr    = r.ins;
      bus.MemReady = r.mrdy;
      bus.ZERO     = r.z;
      exp_r        = r;
      exp_valid    = 1'b1;
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
  endtask

  // Compare every driven cycle away from the rising edge.
  always @(negedge clk) begin
    logic [21:0] got;
    if (exp_valid) begin
      cyc++;
      got = {bus.ALUCtrl, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.AdrSrc,
             bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemRead,
             bus.InstrDone, bus.Illegal};
      total++;
      if (got !== outs(exp_r)) begin
        bad++;
        $display("FAIL cycle_outputs cyc=%0d instr=%08h rst=%0b mrdy=%0b zero=%0b got=%06h want=%06h",
                 cyc, exp_r.ins, exp_r.rs, exp_r.mrdy, exp_r.z, got, outs(exp_r));
      end
      if (bus.InstrDone === 1'b1) done_seen++;
      if (exp_r.done) done_want++;
    end
  end

  initial begin
    int k;
    int wf;
    int wm;
    rst          = 1'b1;
    bus.Instr    = '0;
    bus.ZERO     = 1'b0;
    bus.MemReady = 1'b0;
    @(posedge clk);
    #1;

    reset_recs(32'h0, 2, 1'b1);
    build(32'h40D75733, 0, 0, 1'b0);
    pin("rst_then_sra_len", q.size(), 6);
    pin("rst_fetch_irwrite", q[2].irw, 1);
    pin("rst_fetch_srcb", q[2].b, 2);
    pin("sra_aluctrl", q[4].alu, 13);
    pin("sra_regwrite_c4", q[5].rw, 1);
    run_q();

    build(32'h00C5A633, 0, 0, 1'b0);
    pin("slt_aluctrl", q[2].alu, 2);
    run_q();

    build(32'h40C5A633, 0, 0, 1'b0);
    pin("slt_alt_trap", q[2].ill, 1);
    run_q();

    build(32'h0042A303, 0, 2, 1'b0);
    pin("lw_wait_len", q.size(), 7);
    pin("lw_rd_hold", q[3].mr + q[4].mr + q[5].mr + q[3].adr + q[4].adr + q[5].adr, 6);
    pin("lw_wb_resultsrc", q[6].res, 1);
    run_q();

    build(32'h00B50463, 0, 0, 1'b1);
    pin("beq_taken_len", q.size(), 3);
    pin("beq_taken_pcw", q[2].pcw, 1);
    run_q();
    build(32'h00B50463, 0, 0, 1'b0);
    pin("beq_not_taken_pcw", q[2].pcw, 0);
    run_q();
    build(32'h00B57463, 0, 0, 1'b1);
    pin("bgeu_aluctrl", q[2].alu, 3);
    pin("bgeu_pcw", q[2].pcw, 1);
    run_q();

    build(32'h008000EF, 0, 0, 1'b0);
    pin("jal_len", q.size(), 4);
    pin("jal_pcw", q[2].pcw, 1);
    pin("jal_wb", q[3].rw, 1);
    run_q();
    build(32'h123450B7, 0, 0, 1'b0);
    pin("lui_srca", q[2].a, 3);
    pin("lui_imm", q[2].imm, 4);
    run_q();

    build(32'h0062A023, 0, 0, 1'b0);
    pin("sw_len", q.size(), 4);
    run_q();
    build(32'h0062A023, 0, 3, 1'b0);
    while (q.size() > 4) void'(q.pop_back());
    reset_recs(32'h0062A023, 1, 1'b0);
    run_q();

    for (int n = 0; n < 300; n++) begin
      k  = $urandom_range(0, 11);
      wf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      wm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      build(gen(k), wf, wm, 1'($urandom));
      run_q();
    end

    pin("instrdone_count", done_seen, done_want);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Moore-style control FSM for the multicycle RV32I datapath.
- It is the producer side of the ALU interface: it generates `ALUCtrl` and the operand/result selects, and it consumes the ALU `ZERO` flag for branch resolution.
- It sequences fetch, decode, execute, memory and writeback, and handshakes with unified instruction/data memory through `MemReady`.
- It sits between the instruction register and every datapath enable.

## Interface
Parameters:
- `ALUCTRL_WIDTH`, default 4: width of `ALUCtrl`. It must match the ALU.
- `DATA_WIDTH`, default 32: instruction width.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Instr`  in  32  current instruction-register contents.
- `ZERO`  in  1  ALU zero flag, valid in the same cycle as the ALU operands.
- `MemReady`  in  1  memory completes the current access this cycle.
- `ALUCtrl`  out  4  ALU opcode: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111.
- `ALUSrcA`  out  2  operand A select: 00 PC, 01 OldPC, 10 rs1, 11 zero.
- `ALUSrcB`  out  2  operand B select: 00 rs2, 01 immediate, 10 constant 4.
- `ResultSrc`  out  2  result select: 00 ALUOut register, 01 read data, 10 live ALU result.
- `ImmSrc`  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- `AdrSrc`  out  1  memory address select: 0 PC, 1 Result.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `MemRead`  out  1 each  datapath enables.
- `InstrDone`  out  1  one-cycle pulse on the final cycle of each instruction.
- `Illegal`  out  1  sticky flag for an unsupported encoding.

## Operation
States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JAL, LUI, TRAP.

Default output values: every enable 0, all selects 0, `ALUCtrl`=0000.

- **FETCH**
  - Outputs: `AdrSrc`=0, `MemRead`=1, `ALUSrcA`=PC, `ALUSrcB`=4, add, `ResultSrc`=10.
  - `IRWrite` = `PCWrite` = `MemReady`.
  - Stays in FETCH while `MemReady`=0; goes to DECODE when `MemReady`=1.
- **DECODE**
  - Computes OldPC+imm into ALUOut: `ALUSrcA`=OldPC, `ALUSrcB`=imm, add. `ImmSrc` is derived from the opcode.
  - Dispatch by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 / 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0110111 → LUI
    - anything else → TRAP
- **EXEC_R**
  - rs1 op rs2, with `ALUCtrl` = {Instr[30], funct3}.
  - funct7 must be 0000000, or 0100000 only when funct3 ∈ {000, 101}. Any other funct7 sends DECODE to TRAP.
- **EXEC_I**
  - rs1 op imm, with `ALUCtrl` = {funct3==101 ? Instr[30] : 0, funct3}.
  - For funct3=001, Instr[31:25] must be 0, otherwise TRAP.
- **ALU_WB**
  - `RegWrite`=1, `ResultSrc`=00, `InstrDone`=1, then → FETCH.
  - Reached from EXEC_R, EXEC_I, JAL and LUI.
- **MEM_ADDR**
  - rs1+imm, with `ImmSrc` = I for loads and S for stores.
  - Loads → MEM_RD; stores → MEM_WR. Only funct3=010 is legal, otherwise TRAP.
- **MEM_RD**
  - `AdrSrc`=1, `MemRead`=1. Held until `MemReady`, then → MEM_WB.
- **MEM_WB**
  - `ResultSrc`=01, `RegWrite`=1, `InstrDone`=1, then → FETCH.
- **MEM_WR**
  - `AdrSrc`=1, `MemWrite`=1, held until `MemReady`.
  - On `MemReady` it pulses `InstrDone` and goes → FETCH.
- **BRANCH**
  - Compares rs1 with rs2; `ResultSrc`=00, so the target comes from ALUOut.
  - Per funct3:

    | funct3 | Instruction | ALUCtrl | Taken when |
    |---|---|---|---|
    | 000 | BEQ | sub | ZERO=1 |
    | 001 | BNE | sub | ZERO=0 |
    | 100 | BLT | slt | ZERO=0 |
    | 101 | BGE | slt | ZERO=1 |
    | 110 | BLTU | sltu | ZERO=0 |
    | 111 | BGEU | sltu | ZERO=1 |
    | 010, 011 | — | — | TRAP |

  - `PCWrite` = taken. `InstrDone`=1, then → FETCH.
- **JAL**
  - `PCWrite`=1 with `ResultSrc`=00, loading the target computed in DECODE.
  - In parallel it computes OldPC+4 with add; ALUOut captures it. → ALU_WB.
- **LUI**
  - `ALUSrcA`=zero, `ALUSrcB`=imm (U), add. → ALU_WB.
- **TRAP**
  - `Illegal`=1; all enables 0. Stays in TRAP until `rst`.

## Timing
- State register updates on the rising edge of `clk`.
- Outputs are combinational from the state and `Instr`. `PCWrite` and `IRWrite` also depend on `ZERO` and `MemReady` in the same cycle.
- Reset behaviour:
  - While `rst`=1, every enable, `InstrDone` and `Illegal` are forced to 0 combinationally, and all selects are 0.
  - The edge with `rst`=1 loads FETCH.
  - Reset mid-access drops `MemWrite`/`MemRead` in the same cycle; no partial instruction retires.
- Latency with zero-wait memory (`MemReady`=1 in every access cycle):

  | Instruction | Cycles |
  |---|---|
  | Branch | 3 |
  | R-type, I-type, JAL, LUI, SW | 4 |
  | LW | 5 |

  Each cycle of `MemReady`=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- `InstrDone` is asserted exactly once per instruction, on its last cycle. It is never asserted in FETCH.
- `MemReady` is ignored in every state other than FETCH, MEM_RD and MEM_WR.

## Test plan
- **Reset:** hold `rst` 2 cycles → all enables 0, `Illegal`=0. Release with `MemReady`=1 → cycle 1 shows `IRWrite`=`PCWrite`=1, `ALUSrcB`=10, `ALUCtrl`=0000.
- **R-type decode:** `Instr`=0x40D75733 (sra x14,x14,x13) → `ALUCtrl`=1101 in EXEC_R, `RegWrite`=1 on cycle 4. `Instr`=0x00C5A633 (slt) → `ALUCtrl`=0010. `Instr`=0x40C5A633 (funct7 0100000 with slt) → TRAP, `Illegal`=1.
- **LW with waits:** `Instr`=0x0042A303 with `MemReady` low for 2 cycles in MEM_RD → `MemRead`=`AdrSrc`=1 held for 3 cycles, then MEM_WB with `ResultSrc`=01 and `RegWrite`=1. Total 7 cycles.
- **Branches:**
  - BEQ (0x00B50463) with `ZERO`=1 → `PCWrite`=1 in BRANCH.
  - BEQ with `ZERO`=0 → `PCWrite`=0.
  - BGEU (funct3 111) with `ZERO`=1 → `ALUCtrl`=0011, `PCWrite`=1.
  - Each takes 3 cycles.
- **JAL and LUI:** JAL (0x008000EF) → JAL state `PCWrite`=1, `ResultSrc`=00; next cycle `RegWrite`=1. LUI (0x123450B7) → `ALUSrcA`=11, `ImmSrc`=100.
- **Reset mid-store:** SW, assert `rst` during MEM_WR with `MemReady`=0 → `MemWrite`=0 in the same cycle, FETCH on the next edge, no `InstrDone` pulse.
